// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg: shared bus-arbiter states, active-low enable levels, read/write codes and default master count
package bus_arbiter_pkg;
  typedef enum logic {BUS_ARB_STATE_IDLE = 1'b0, BUS_ARB_STATE_OWNED = 1'b1} state_t;
  localparam logic ENABLE_ = 1'b0;
  localparam logic DISABLE_ = 1'b1;
  localparam logic READ = 1'b1;
  localparam logic WRITE = 1'b0;
  localparam int DEFAULT_NUM_MASTERS = 4;
endpackage

// File: rtl/bus_arb_rr_pick.sv
// bus_arb_rr_pick: combinational round-robin picker (req active-high, last, excl mask -> valid, win)
module bus_arb_rr_pick
  import bus_arbiter_pkg::*;
#(
  parameter int N = DEFAULT_NUM_MASTERS,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  input  logic [N-1:0]  excl,
  output logic          valid,
  output logic [IW-1:0] win
);
  logic [N-1:0] cand;
  logic [2*N-1:0] dbl;
  logic [N-1:0] rot;
  assign cand = req & ~excl;
  assign dbl = {cand, cand};
  assign rot = N'(dbl >> (int'(last) + 1));
  always_comb begin
    valid = 1'b0;
    win = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        valid = 1'b1;
        win = IW'((int'(last) + 1 + i) % N);
      end
    end
  end
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin shared-bus arbiter with forced-revoke timeout (clk/reset, m_* masters in, m_grnt_n out, s_* shared bus, owner/bus_busy/timeout_err status)
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = DEFAULT_NUM_MASTERS,
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32,
  parameter int TIMEOUT = 255,
  localparam int OW = $clog2(NUM_MASTERS),
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_MASTERS-1:0]        m_req_n,
  output logic [NUM_MASTERS-1:0]        m_grnt_n,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
  input  logic [NUM_MASTERS-1:0]        m_as_n,
  input  logic [NUM_MASTERS-1:0]        m_rw,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_wrdata,
  output logic [ADDR_W-1:0]             s_addr,
  output logic                          s_as_n,
  output logic                          s_rw,
  output logic [DATA_W-1:0]             s_wrdata,
  output logic [OW-1:0]                 owner,
  output logic                          bus_busy,
  output logic                          timeout_err
);
  state_t state, state_d;
  logic [OW-1:0] owner_d, last, last_d, win;
  logic [CW-1:0] cnt, cnt_d;
  logic [NUM_MASTERS-1:0] grnt_d, excl;
  logic fire, arb, valid;
  assign fire = state == BUS_ARB_STATE_OWNED && !m_req_n[owner] && TIMEOUT != 0 && cnt == CW'(TIMEOUT - 1);
  assign arb = state == BUS_ARB_STATE_IDLE || m_req_n[owner] || fire;
  assign excl = {{(NUM_MASTERS-1){1'b0}}, fire} << owner;
  bus_arb_rr_pick #(.N(NUM_MASTERS)) u_pick (
    .req(~m_req_n),
    .last(last),
    .excl(excl),
    .valid(valid),
    .win(win)
  );
  always_comb begin
    state_d = arb ? (valid ? BUS_ARB_STATE_OWNED : BUS_ARB_STATE_IDLE) : state;
    owner_d = arb && valid ? win : owner;
    last_d = arb && valid ? win : last;
    cnt_d = arb ? '0 : cnt + 1'b1;
    grnt_d = arb ? (valid ? ~({{(NUM_MASTERS-1){1'b0}}, 1'b1} << win) : {NUM_MASTERS{DISABLE_}}) : m_grnt_n;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= BUS_ARB_STATE_IDLE;
      owner <= '0;
      last <= OW'(NUM_MASTERS - 1);
      cnt <= '0;
      m_grnt_n <= {NUM_MASTERS{DISABLE_}};
      timeout_err <= 1'b0;
    end else begin
      state <= state_d;
      owner <= owner_d;
      last <= last_d;
      cnt <= cnt_d;
      m_grnt_n <= grnt_d;
      timeout_err <= fire;
    end
  end
  assign bus_busy = state == BUS_ARB_STATE_OWNED;
  assign s_addr = bus_busy ? m_addr[owner*ADDR_W +: ADDR_W] : '0;
  assign s_as_n = bus_busy ? m_as_n[owner] : DISABLE_;
  assign s_rw = bus_busy ? m_rw[owner] : READ;
  assign s_wrdata = bus_busy ? m_wrdata[owner*DATA_W +: DATA_W] : '0;
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: table, directed timeout and randomized checks of bus_arbiter against a behavioural model
module tb_bus_arbiter;
  localparam int N = 4;
  localparam int AW = 30;
  localparam int DW = 32;
  localparam int TO = 8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [N-1:0] m_req_n = '1;
  logic [N-1:0] m_grnt_n;
  logic [N*AW-1:0] m_addr = '0;
  logic [N-1:0] m_as_n = '1;
  logic [N-1:0] m_rw = '1;
  logic [N*DW-1:0] m_wrdata = '0;
  logic [AW-1:0] s_addr;
  logic s_as_n, s_rw, bus_busy, timeout_err;
  logic [DW-1:0] s_wrdata;
  logic [1:0] owner;
  int vectors = 0;
  int miscompares = 0;
  bit md_busy, md_terr;
  int md_owner, md_last, md_held;
  typedef struct {
    logic rst;
    logic [3:0] req_n;
    logic [3:0] grnt_n;
    logic busy;
    logic terr;
  } vec_t;
  vec_t tbl[34];
  always #5 clk = ~clk;
  bus_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk),
    .reset(reset),
    .m_req_n(m_req_n),
    .m_grnt_n(m_grnt_n),
    .m_addr(m_addr),
    .m_as_n(m_as_n),
    .m_rw(m_rw),
    .m_wrdata(m_wrdata),
    .s_addr(s_addr),
    .s_as_n(s_as_n),
    .s_rw(s_rw),
    .s_wrdata(s_wrdata),
    .owner(owner),
    .bus_busy(bus_busy),
    .timeout_err(timeout_err)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask
  // Behavioural reference: the owner holds while requesting, at most TO cycles;
  // otherwise the bus goes to the first requester after the previous owner.
  task automatic model_edge();
    bit fire, arb;
    int w, c;
    if (reset) begin
      md_busy = 0;
      md_owner = 0;
      md_last = N - 1;
      md_held = 0;
      md_terr = 0;
    end else begin
      fire = md_busy && !m_req_n[md_owner] && md_held == TO;
      arb = !md_busy || m_req_n[md_owner] || fire;
      md_terr = fire;
      if (arb) begin
        w = -1;
        for (int k = N; k >= 1; k--) begin
          c = (md_last + k) % N;
          if (!m_req_n[c] && !(fire && c == md_owner)) w = c;
        end
        if (w >= 0) begin
          md_busy = 1;
          md_owner = w;
          md_last = w;
          md_held = 1;
        end else md_busy = 0;
      end else md_held++;
    end
  endtask
  task automatic check_model();
    logic [3:0] g;
    g = md_busy ? ~(4'b0001 << md_owner) : 4'b1111;
    chk("grant", m_grnt_n, g);
    chk("bus_busy", bus_busy, md_busy);
    chk("timeout_err", timeout_err, md_terr);
    if (md_busy) chk("owner", owner, md_owner);
    chk("s_addr", s_addr, md_busy ? m_addr[md_owner*AW +: AW] : '0);
    chk("s_as_n", s_as_n, md_busy ? m_as_n[md_owner] : 1'b1);
    chk("s_rw", s_rw, md_busy ? m_rw[md_owner] : 1'b1);
    chk("s_wrdata", s_wrdata, md_busy ? m_wrdata[md_owner*DW +: DW] : '0);
  endtask
  task automatic step(input logic r, input logic [3:0] rq);
    reset = r;
    m_req_n = rq;
    for (int i = 0; i < N; i++) begin
      m_addr[i*AW +: AW] = AW'($urandom);
      m_wrdata[i*DW +: DW] = $urandom;
    end
    m_as_n = 4'($urandom);
    m_rw = 4'($urandom);
    model_edge();
    @(posedge clk);
    #1;
    check_model();
  endtask
  initial begin
    int idle_cnt, terr_cnt;
    logic [3:0] rq;
    tbl[0] = '{1'b1, 4'b1111, 4'b1111, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 4'b1111, 4'b1111, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 4'b1110, 4'b1110, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 4'b1110, 4'b1110, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 4'b1110, 4'b1110, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 4'b1111, 4'b1111, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 4'b1111, 4'b1111, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 4'b1111, 4'b1111, 1'b0, 1'b0};
    tbl[8] = '{1'b0, 4'b0000, 4'b1110, 1'b1, 1'b0};
    tbl[9] = '{1'b0, 4'b0000, 4'b1110, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 4'b0000, 4'b1110, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 4'b0001, 4'b1101, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 4'b0001, 4'b1101, 1'b1, 1'b0};
    tbl[13] = '{1'b0, 4'b0001, 4'b1101, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 4'b0011, 4'b1011, 1'b1, 1'b0};
    tbl[15] = '{1'b0, 4'b0011, 4'b1011, 1'b1, 1'b0};
    tbl[16] = '{1'b0, 4'b0011, 4'b1011, 1'b1, 1'b0};
    tbl[17] = '{1'b0, 4'b0111, 4'b0111, 1'b1, 1'b0};
    tbl[18] = '{1'b0, 4'b0111, 4'b0111, 1'b1, 1'b0};
    tbl[19] = '{1'b0, 4'b0111, 4'b0111, 1'b1, 1'b0};
    tbl[20] = '{1'b0, 4'b1110, 4'b1110, 1'b1, 1'b0};
    tbl[21] = '{1'b0, 4'b1011, 4'b1011, 1'b1, 1'b0};
    tbl[22] = '{1'b0, 4'b1001, 4'b1011, 1'b1, 1'b0};
    tbl[23] = '{1'b0, 4'b0101, 4'b0111, 1'b1, 1'b0};
    tbl[24] = '{1'b0, 4'b1101, 4'b1101, 1'b1, 1'b0};
    tbl[25] = '{1'b0, 4'b1111, 4'b1111, 1'b0, 1'b0};
    tbl[26] = '{1'b0, 4'b1011, 4'b1011, 1'b1, 1'b0};
    tbl[27] = '{1'b0, 4'b1001, 4'b1011, 1'b1, 1'b0};
    tbl[28] = '{1'b0, 4'b1101, 4'b1101, 1'b1, 1'b0};
    tbl[29] = '{1'b0, 4'b1111, 4'b1111, 1'b0, 1'b0};
    tbl[30] = '{1'b0, 4'b0111, 4'b0111, 1'b1, 1'b0};
    tbl[31] = '{1'b1, 4'b0111, 4'b1111, 1'b0, 1'b0};
    tbl[32] = '{1'b0, 4'b0110, 4'b1110, 1'b1, 1'b0};
    tbl[33] = '{1'b0, 4'b1111, 4'b1111, 1'b0, 1'b0};
    for (int i = 0; i < 34; i++) begin
      step(tbl[i].rst, tbl[i].req_n);
      chk($sformatf("row%0d grant", i), m_grnt_n, tbl[i].grnt_n);
      chk($sformatf("row%0d busy", i), bus_busy, tbl[i].busy);
      chk($sformatf("row%0d timeout_err", i), timeout_err, tbl[i].terr);
    end
    step(1'b1, 4'b1111);
    step(1'b0, 4'b1110);
    chk("solo first grant", m_grnt_n, 4'b1110);
    idle_cnt = 0;
    terr_cnt = 0;
    for (int c = 2; c <= 27; c++) begin
      step(1'b0, 4'b1110);
      if (m_grnt_n == 4'b1111) idle_cnt++;
      if (timeout_err) terr_cnt++;
      if (c % 9 == 0) chk($sformatf("solo idle c%0d", c), {timeout_err, m_grnt_n}, 5'b11111);
    end
    chk("solo idle count", idle_cnt, 3);
    chk("solo timeout count", terr_cnt, 3);
    step(1'b1, 4'b1111);
    step(1'b0, 4'b1110);
    repeat (7) step(1'b0, 4'b1100);
    chk("hog still owns", m_grnt_n, 4'b1110);
    step(1'b0, 4'b1100);
    chk("revoke grant", m_grnt_n, 4'b1101);
    chk("revoke pulse", timeout_err, 1'b1);
    step(1'b0, 4'b1101);
    chk("pulse one cycle", timeout_err, 1'b0);
    chk("m1 keeps bus", m_grnt_n, 4'b1101);
    rq = 4'b1111;
    repeat (700) begin
      for (int i = 0; i < N; i++) if ($urandom_range(5) == 0) rq[i] = ~rq[i];
      step($urandom_range(80) == 0, rq);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
